mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage with integrated MEM/WB register, directly upstream of the write-back mux stage.
- Takes EX/MEM results and performs byte/half/word loads and stores over a req/ready data-memory handshake, including lane steering and load extension.
- Stalls upstream while an access is outstanding.
- Registers alu_result, extended load data, pc_adder and control (MemtoReg, DataC, RegWrite, write_reg) for write-back.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ waiting for dmem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM slot holds a valid instruction.
- alu_result  in  32  address for memory ops, result otherwise.
- store_data  in  32  rt value for stores.
- MemRead  in  1  load.
- MemWrite  in  1  store. MemRead and MemWrite are never both 1.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_unsigned  in  1  zero-extend loads (lbu/lhu).
- MemtoReg, DataC, RegWrite  in  1 each  WB control, passed through.
- write_reg  in  5  destination register.
- pc_adder  in  32  PC+4/8 for link writes.
- mem_stall  out  1  upstream must hold all inputs stable while high.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address ({alu_result[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-steered store data.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read word, valid with dmem_ready.
- wb_valid  out  1  WB slot valid.
- wb_alu_result  out  32  registered result.
- wb_read_data_mem  out  32  registered load data.
- wb_pc_adder  out  32  registered link value.
- wb_MemtoReg, wb_DataC, wb_RegWrite  out  1 each  registered control.
- wb_write_reg  out  5  registered destination.
- misalign_exc  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on an access timeout.

Behaviour:
- Reset: state IDLE; all dmem_* outputs, wb_* outputs, misalign_exc, bus_err and the timeout counter are 0. A reset during REQ drops dmem_req at that same edge, with no WB write.
- Memory op = ex_valid & (MemRead|MemWrite).
- Non-memory instruction in IDLE: mem_stall=0. WB registers load the inputs at the next edge, with wb_valid=ex_valid and wb_read_data_mem=0. Latency is 1 cycle.
- IDLE, aligned memory op:
  - mem_stall=1; wb_valid is cleared to 0 at the next edge (bubble).
  - At that edge, register dmem_addr, dmem_we=MemWrite, dmem_be and dmem_wdata, set dmem_req=1, and go to REQ.
- Alignment rule:
  - Word: misaligned if addr[1:0]!=0.
  - Half: misaligned if addr[0]!=0.
  - Byte: never misaligned.
- Misaligned op in IDLE:
  - No request is issued; mem_stall=0.
  - At the next edge: misalign_exc=1 for one cycle; WB loads normally except wb_RegWrite=0 and wb_read_data_mem=0.
- REQ state:
  - dmem_req, addr, we, be and wdata are held stable.
  - mem_stall = ~dmem_ready.
  - On an edge with dmem_ready=1, load the WB registers: wb_valid=1, wb_read_data_mem = extended load (0 for stores). Clear dmem_req and return to IDLE.
  - Upstream advances at that same edge.
  - Memory-op latency is 2 cycles minimum; each wait cycle adds 1.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each REQ cycle without ready.
  - When it reaches TIMEOUT_CYCLES: abort, clear dmem_req, bus_err pulse, WB loaded with wb_RegWrite=0, return to IDLE, counter cleared.
  - dmem_ready arriving in the same cycle as expiry wins, and the access completes normally.
- Store steering (little-endian):
  - Byte: wdata = {4{sd[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{sd[15:0]}}, be = 4'b0011 << addr[1:0].
  - Word: be = 4'b1111.
- Load extension:
  - Byte: lane = rdata[8*addr[1:0] +: 8].
  - Half: lane = rdata[16*addr[1] +: 16].
  - Sign- or zero-extend to 32 bits per mem_unsigned.
  - Word: passthrough.
- The byte offset and size are latched at issue for use at completion.
- ex_valid=0 in IDLE: bubble, wb_valid=0, no request.
- Back-to-back memory ops: IDLE is re-entered for 1 cycle between accesses; dmem_req is never high on consecutive edges across two different accesses.

Test Plan:
- ALU op: alu_result=0x1234, RegWrite=1, write_reg=5 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_write_reg=5, mem_stall never 1.
- lb at addr 0x103, rdata=0x80FF_0000, ready after 2 wait cycles -> dmem_addr=0x100, mem_stall high 3 cycles, wb_read_data_mem=0xFFFF_FF80. The same access as lbu -> 0x0000_0080.
- sh at 0x202, store_data=0xDEAD_BEEF -> dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, wb_RegWrite passes through.
- lw at 0x06 -> no dmem_req, misalign_exc pulses once, wb_valid=1 with wb_RegWrite=0.
- TIMEOUT_CYCLES=4, dmem_ready held 0 -> dmem_req drops after 4 REQ cycles, bus_err pulses once, mem_stall released, wb_RegWrite=0.
- rst asserted during REQ -> next edge dmem_req=0, all wb_* outputs 0, state IDLE; a subsequent lw at 0x0 completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage with integrated MEM/WB register: sized loads/stores over a
// req/ready data-memory bus, lane steering, load extension, misalign and timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        MemtoReg,
  input  logic        DataC,
  input  logic        RegWrite,
  input  logic [4:0]  write_reg,
  input  logic [31:0] pc_adder,
  output logic        mem_stall,
  mem_access_stage_if.master dmem,
  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data_mem,
  output logic [31:0] wb_pc_adder,
  output logic        wb_MemtoReg,
  output logic        wb_DataC,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_write_reg,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d, wb_m2r_q, wb_m2r_d, wb_datac_q, wb_datac_d;
  logic        wb_rw_q, wb_rw_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d, wb_pc_q, wb_pc_d;
  logic [4:0]  wb_wr_q, wb_wr_d;
  logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

  logic        mem_op, misaligned, expire;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    mem_op = ex_valid & (MemRead | MemWrite);
    unique case (mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result[0];
      default: misaligned = |alu_result[1:0];
    endcase
    unique case (mem_size)
      2'b00: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << alu_result[1:0];
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Load lane selection uses the offset/size latched at issue, not the live inputs.
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = dmem.dmem_rdata[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      default: ld_byte = dmem.dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    unique case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  assign expire = (TIMEOUT_CYCLES != 0) && !dmem.dmem_ready &&
                  ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    wb_valid_d = wb_valid_q;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    wb_pc_d    = wb_pc_q;
    wb_m2r_d   = wb_m2r_q;
    wb_datac_d = wb_datac_q;
    wb_rw_d    = wb_rw_q;
    wb_wr_d    = wb_wr_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    mem_stall  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          mem_stall  = 1'b1;
          wb_valid_d = 1'b0;
          req_d      = 1'b1;
          we_d       = MemWrite;
          addr_d     = {alu_result[31:2], 2'b00};
          be_d       = st_be;
          wdata_d    = st_wdata;
          off_d      = alu_result[1:0];
          size_d     = mem_size;
          uns_d      = mem_unsigned;
          cnt_d      = '0;
          state_d    = REQ;
        end else begin
          wb_valid_d = ex_valid;
          wb_alu_d   = alu_result;
          wb_rdata_d = '0;
          wb_pc_d    = pc_adder;
          wb_m2r_d   = MemtoReg;
          wb_datac_d = DataC;
          wb_rw_d    = RegWrite & ~(mem_op & misaligned);
          wb_wr_d    = write_reg;
          misalign_d = mem_op & misaligned;
        end
      end
      REQ: begin
        // Expiry also releases the stall so the aborted instruction retires instead of reissuing.
        if (dmem.dmem_ready || expire) begin
          wb_valid_d = 1'b1;
          wb_alu_d   = alu_result;
          wb_rdata_d = (dmem.dmem_ready && !we_q) ? ld_data : '0;
          wb_pc_d    = pc_adder;
          wb_m2r_d   = MemtoReg;
          wb_datac_d = DataC;
          wb_rw_d    = dmem.dmem_ready ? RegWrite : 1'b0;
          wb_wr_d    = write_reg;
          bus_err_d  = ~dmem.dmem_ready;
          req_d      = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
      wb_pc_q    <= '0;
      wb_m2r_q   <= 1'b0;
      wb_datac_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_wr_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      wb_pc_q    <= wb_pc_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_datac_q <= wb_datac_d;
      wb_rw_q    <= wb_rw_d;
      wb_wr_q    <= wb_wr_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_valid         = wb_valid_q;
  assign wb_alu_result    = wb_alu_q;
  assign wb_read_data_mem = wb_rdata_q;
  assign wb_pc_adder      = wb_pc_q;
  assign wb_MemtoReg      = wb_m2r_q;
  assign wb_DataC         = wb_datac_q;
  assign wb_RegWrite      = wb_rw_q;
  assign wb_write_reg     = wb_wr_q;
  assign misalign_exc     = misalign_q;
  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle access timeout.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, MemRead, MemWrite, mem_unsigned, MemtoReg, DataC, RegWrite;
  logic [31:0] alu_result, store_data, pc_adder;
  logic [1:0]  mem_size;
  logic [4:0]  write_reg;
  logic        mem_stall, wb_valid, wb_MemtoReg, wb_DataC, wb_RegWrite, misalign_exc, bus_err;
  logic [31:0] wb_alu_result, wb_read_data_mem, wb_pc_adder;
  logic [4:0]  wb_write_reg;

  int checks = 0;
  int errors = 0;
  int stalls, reqs;

  always #5 clk = ~clk;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .MemtoReg(MemtoReg),
    .DataC(DataC), .RegWrite(RegWrite), .write_reg(write_reg), .pc_adder(pc_adder),
    .mem_stall(mem_stall), .dmem(dmem), .wb_valid(wb_valid),
    .wb_alu_result(wb_alu_result), .wb_read_data_mem(wb_read_data_mem),
    .wb_pc_adder(wb_pc_adder), .wb_MemtoReg(wb_MemtoReg), .wb_DataC(wb_DataC),
    .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; MemRead = 0; MemWrite = 0; mem_size = 2'b00; mem_unsigned = 0;
    MemtoReg = 0; DataC = 0; RegWrite = 0; write_reg = '0;
    alu_result = '0; store_data = '0; pc_adder = '0;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rdst);
    ex_valid = 1; MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = addr; store_data = sd; RegWrite = 1; MemtoReg = rd; DataC = 0;
    write_reg = rdst; pc_adder = 32'h0000_0400;
  endtask

  // Clocks the current op until mem_stall drops; ready is given after `waits` REQ cycles.
  task automatic run_access(input int waits, input logic [31:0] rd,
                            output int n_stall, output int n_req);
    int  w;
    bit  done;
    n_stall = 0; n_req = 0; w = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (dmem.dmem_req && w >= waits) begin
        dmem.dmem_ready = 1; dmem.dmem_rdata = rd;
      end else begin
        dmem.dmem_ready = 0;
      end
      #1;
      if (dmem.dmem_req) begin n_req++; w++; end
      if (mem_stall) n_stall++;
      else done = 1;
      tick();
    end
    dmem.dmem_ready = 0;
    dmem.dmem_rdata = '0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL access_bound observed=stalled expected=released");
    end
  endtask

  initial begin
    dmem.dmem_ready = 0;
    dmem.dmem_rdata = '0;
    idle_inputs();
    rst = 1;
    tick(); tick();
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_addr", dmem.dmem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_misalign", misalign_exc, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 0;

    // ALU op: 1-cycle latency, never stalls
    ex_valid = 1; alu_result = 32'h1234; RegWrite = 1; write_reg = 5; DataC = 1;
    pc_adder = 32'h40;
    #1 chk("alu_stall", mem_stall, 0);
    tick();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_alu", wb_alu_result, 32'h1234);
    chk("alu_wb_wr", wb_write_reg, 5);
    chk("alu_wb_rw", wb_RegWrite, 1);
    chk("alu_wb_datac", wb_DataC, 1);
    chk("alu_wb_pc", wb_pc_adder, 32'h40);
    chk("alu_wb_rdata", wb_read_data_mem, 0);
    chk("alu_req", dmem.dmem_req, 0);

    // lb 0x103, two wait cycles
    set_mem(1, 0, 2'b00, 0, 32'h103, '0, 7);
    run_access(2, 32'h80FF_0000, stalls, reqs);
    chk("lb_stalls", stalls, 3);
    chk("lb_reqs", reqs, 3);
    chk("lb_addr", dmem.dmem_addr, 32'h100);
    chk("lb_be", dmem.dmem_be, 4'b1000);
    chk("lb_we", dmem.dmem_we, 0);
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_rdata", wb_read_data_mem, 32'hFFFF_FF80);
    chk("lb_wb_wr", wb_write_reg, 7);

    // lbu back-to-back: request gap of one IDLE cycle
    set_mem(1, 0, 2'b00, 1, 32'h103, '0, 7);
    chk("b2b_req_gap", dmem.dmem_req, 0);
    run_access(2, 32'h80FF_0000, stalls, reqs);
    chk("lbu_rdata", wb_read_data_mem, 32'h0000_0080);

    // lh 0x2: upper half, sign-extended
    set_mem(1, 0, 2'b01, 0, 32'h2, '0, 8);
    run_access(1, 32'h8001_1234, stalls, reqs);
    chk("lh_stalls", stalls, 2);
    chk("lh_be", dmem.dmem_be, 4'b1100);
    chk("lh_rdata", wb_read_data_mem, 32'hFFFF_8001);

    // sh 0x202, immediate ready: 2-cycle latency
    set_mem(0, 1, 2'b01, 0, 32'h202, 32'hDEAD_BEEF, 9);
    run_access(0, 32'h5555_5555, stalls, reqs);
    chk("sh_stalls", stalls, 1);
    chk("sh_we", dmem.dmem_we, 1);
    chk("sh_addr", dmem.dmem_addr, 32'h200);
    chk("sh_be", dmem.dmem_be, 4'b1100);
    chk("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_wb_rw", wb_RegWrite, 1);
    chk("sh_wb_rdata", wb_read_data_mem, 0);

    // lw 0x06: misaligned, no request
    set_mem(1, 0, 2'b10, 0, 32'h6, '0, 10);
    #1 chk("mis_stall", mem_stall, 0);
    tick();
    chk("mis_req", dmem.dmem_req, 0);
    chk("mis_exc", misalign_exc, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_rw", wb_RegWrite, 0);
    chk("mis_wb_rdata", wb_read_data_mem, 0);
    idle_inputs();
    tick();
    chk("mis_pulse_end", misalign_exc, 0);
    chk("bubble_wb_valid", wb_valid, 0);

    // lw 0x10 with ready never arriving: timeout after 4 REQ cycles
    set_mem(1, 0, 2'b10, 0, 32'h10, '0, 11);
    run_access(99, 32'h0, stalls, reqs);
    chk("to_reqs", reqs, 4);
    chk("to_stalls", stalls, 4);
    chk("to_req", dmem.dmem_req, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_RegWrite, 0);
    idle_inputs();
    tick();
    chk("to_pulse_end", bus_err, 0);

    // ready on the expiry cycle wins
    set_mem(1, 0, 2'b10, 0, 32'h10, '0, 12);
    run_access(3, 32'hCAFE_F00D, stalls, reqs);
    chk("exp_ready_reqs", reqs, 4);
    chk("exp_ready_bus_err", bus_err, 0);
    chk("exp_ready_rw", wb_RegWrite, 1);
    chk("exp_ready_rdata", wb_read_data_mem, 32'hCAFE_F00D);

    // reset during REQ
    set_mem(1, 0, 2'b10, 0, 32'h20, '0, 13);
    tick();
    chk("pre_rst_req", dmem.dmem_req, 1);
    idle_inputs();
    rst = 1;
    tick();
    chk("rst_req_drop", dmem.dmem_req, 0);
    chk("rst_wb_valid2", wb_valid, 0);
    chk("rst_wb_rdata2", wb_read_data_mem, 0);
    chk("rst_wb_rw2", wb_RegWrite, 0);
    chk("rst_wb_wr2", wb_write_reg, 0);
    rst = 0;
    set_mem(1, 0, 2'b10, 0, 32'h0, '0, 14);
    run_access(1, 32'h1122_3344, stalls, reqs);
    chk("post_rst_stalls", stalls, 2);
    chk("post_rst_rdata", wb_read_data_mem, 32'h1122_3344);
    chk("post_rst_wb_valid", wb_valid, 1);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
